alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Multi-cycle integer execute unit directly downstream of the ALU control decoder.
- Consumes the decoded alu_operation_type plus two XLEN-bit operands through a valid/ready handshake, and returns the result with a zero flag.
- Logic/arithmetic/compare ops complete in one cycle; shifts run iteratively, one bit per cycle, to keep the barrel shifter out of the execute path.

Parameters:
- XLEN, 32, operand/result width in bits.
- SHAMT_W, $clog2(XLEN), shift-amount width; shift amount is b[SHAMT_W-1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort of any in-flight operation.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request.
- op  input  alu_operation_type  decoded operation (ADD, SUB, SLL, SRL, SRA, XOR, OR, AND, SLT, SLTU).
- a  input  XLEN  operand 1 (rs1).
- b  input  XLEN  operand 2 (rs2 or immediate).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, internal shift counter=0.

State machine:
- IDLE: in_ready=1.
  - On in_valid, capture op/a/b.
  - For a non-shift op, compute and go to DONE.
  - For a shift op with shamt=0, result=a and go to DONE.
  - For a shift op with shamt>0, load the accumulator with a and the counter with shamt, then go to SHIFT.
- SHIFT: in_ready=0.
  - Each cycle shift the accumulator by 1: SLL left with 0 fill; SRL right with 0 fill; SRA right, replicating the MSB.
  - Decrement the counter. When the counter reaches 1 (last step this cycle), go to DONE.
- DONE: out_valid=1 and in_ready=0. result/zero are held stable until out_ready=1, then go to IDLE.
- A new request cannot be accepted in the same cycle a result retires; in_ready rises the cycle after.

Latency (handshake accepted in cycle T):
- Non-shift op, or shift with shamt=0: out_valid at T+1.
- Shift with shamt=n>0: out_valid at T+1+n. Maximum is T+XLEN for n=XLEN-1.

Arithmetic rules (all results XLEN bits; carries and overflow discarded):
- ADD = a+b, wrapping.
- SUB = a-b, wrapping.
- XOR/OR/AND: bitwise.
- SLT: signed compare, result = {XLEN-1 zeros, a<b}.
- SLTU: unsigned compare, same result format.
- zero = (result == 0), registered with result.

Control rules:
- Inputs are sampled only on in_valid & in_ready. Changes to op/a/b while busy have no effect.
- Undefined op encoding: result=0, completes in 1 cycle (no assertion in RTL).
- flush (any state): next state IDLE, out_valid=0. Any pending result is discarded and never presented. flush takes priority over in_valid in the same cycle (no accept). result/zero hold their last values.
- rst has priority over flush. Mid-operation rst forces reset values on the next edge.
- out_ready while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored; the requester must hold it.

Test Plan:
- ADD a=0xFFFFFFFF, b=1 → out_valid at T+1, result=0x00000000, zero=1. SUB a=5, b=7 → result=0xFFFFFFFE, zero=0.
- SLT a=0xFFFFFFFF, b=1 → result=1. SLTU with the same operands → result=0. XOR a=0xA5A5A5A5, b=0xFFFF0000 → 0x5A5AA5A5.
- SRA a=0x80000000, b=31 → in_ready=0 for 31 cycles, out_valid at T+32, result=0xFFFFFFFF. SRL with the same operands → 0x00000001. SLL a=1, b=0 → out_valid at T+1, result=1.
- Backpressure: SLL a=3, b=4 with out_ready held 0 for 5 cycles → result=0x30 stable and out_valid high throughout. Release → out_valid falls next cycle, in_ready rises next cycle.
- flush asserted in the 3rd SHIFT cycle of SLL b=10 → next cycle IDLE, out_valid never asserted. flush together with in_valid in IDLE → request not accepted.
- rst asserted during DONE with out_ready=0 → next cycle out_valid=0, result=0, zero=1, in_ready=1. A subsequent ADD 2+3 returns 5 at T+1.

Source files
------------

// File: rtl/alu_exec.sv
// Multi-cycle integer execute unit: single-cycle logic/arithmetic/compare
// ops, iterative one-bit-per-cycle shifts, valid/ready on both sides.

package alu_exec_pkg;
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLL  = 4'd2,
      OP_SRL  = 4'd3,
      OP_SRA  = 4'd4,
      OP_XOR  = 4'd5,
      OP_OR   = 4'd6,
      OP_AND  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9
   } alu_operation_type;
endpackage

module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  alu_operation_type op,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   result,
   output logic              zero
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   alu_operation_type op_q, op_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              zero_q, zero_d;

   logic [XLEN-1:0]    alu_val;
   logic [XLEN-1:0]    shift_step;
   logic [SHAMT_W-1:0] shamt;
   logic               is_shift;

   assign shamt     = b[SHAMT_W-1:0];
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = zero_q;

   // Single-cycle result for the incoming request (shifts only reach here with shamt=0).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      alu_val  = '0;
      is_shift = 1'b0;
      case (op)
         OP_ADD:  alu_val = a + b;
         OP_SUB:  alu_val = a - b;
         OP_XOR:  alu_val = a ^ b;
         OP_OR:   alu_val = a | b;
         OP_AND:  alu_val = a & b;
         OP_SLT:  alu_val = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_val = {{(XLEN-1){1'b0}}, (a < b)};
         OP_SLL, OP_SRL, OP_SRA: begin
            alu_val  = a;
            is_shift = 1'b1;
         end
         default: alu_val = '0;
      endcase
   end

   // One-bit shift of the accumulator in the direction of the captured op.
   always_comb begin
      shift_step = acc_q;
      case (op_q)
         OP_SLL:  shift_step = {acc_q[XLEN-2:0], 1'b0};
         OP_SRL:  shift_step = {1'b0, acc_q[XLEN-1:1]};
         OP_SRA:  shift_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
         default: shift_step = acc_q;
      endcase
   end

   // Next-state and datapath update; flush overrides everything but reset.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_d = op;
                  if (is_shift && (shamt != '0)) begin
                     acc_d   = a;
                     cnt_d   = shamt;
                     state_d = ST_SHIFT;
                  end else begin
                     result_d = alu_val;
                     zero_d   = (alu_val == '0);
                     state_d  = ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               acc_d = shift_step;
               cnt_d = cnt_q - SHAMT_W'(1);
               if (cnt_q == SHAMT_W'(1)) begin
                  result_d = shift_step;
                  zero_d   = (shift_step == '0);
                  state_d  = ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_ADD;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corner cases, randomized ops
// against a behavioural model, backpressure, flush and reset-in-flight.

module tb_alu_exec;
   import alu_exec_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   alu_operation_type op;
   logic [31:0]       a;
   logic [31:0]       b;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       result;
   logic              zero;

   int n_tests = 0;
   int n_fail  = 0;

   alu_exec #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   // Behavioural reference: plain arithmetic on whole words.
   function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      int unsigned sh;
      sh = int'(y[4:0]);
      case (o)
         4'd0: return x + y;
         4'd1: return x - y;
         4'd2: return x << sh;
         4'd3: return x >> sh;
         4'd4: return 32'($signed(x) >>> sh);
         4'd5: return x ^ y;
         4'd6: return x | y;
         4'd7: return x & y;
         4'd8: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd9: return (x < y) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] o, input logic [31:0] y);
      if ((o == 4'd2 || o == 4'd3 || o == 4'd4) && y[4:0] != 5'd0) return 1 + int'(y[4:0]);
      return 1;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Issue one request from IDLE, wait for the result, check it, retire it.
   task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input int exp_lat, input string name);
      int  cycles;
      bit  busy_ok;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_before_issue: in_ready=%b want 1", name, in_ready);
      end
      op = alu_operation_type'(o); a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      cycles   = 1;
      busy_ok  = 1'b1;
      while (out_valid !== 1'b1 && cycles < 100) begin
         if (in_ready !== 1'b0) busy_ok = 1'b0;
         // Inputs wiggling while busy must have no effect; out_ready with no result is ignored.
         op = alu_operation_type'(4'($urandom_range(0, 15)));
         a = $urandom; b = $urandom;
         out_ready = 1'($urandom_range(0, 1));
         step();
         cycles++;
      end
      n_tests++;
      if (cycles != exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles want %0d", name, cycles, exp_lat);
      end
      n_tests++;
      if (!busy_ok) begin
         n_fail++;
         $display("FAIL %s busy_in_ready: in_ready was high while busy", name);
      end
      n_tests++;
      if (result !== exp_res || zero !== (exp_res == 32'd0) || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s result: got %h zero=%b in_ready=%b want %h zero=%b in_ready=0",
                  name, result, zero, in_ready, exp_res, (exp_res == 32'd0));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s retire: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = OP_ADD; a = '0; b = '0;
      step(); step();
      rst = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h zero=%b want 1/0/0/1",
                  in_ready, out_valid, result, zero);
      end
   endtask

   typedef struct {
      logic [3:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] res;
      int          lat;
   } vec_t;

   task automatic test_directed;
      vec_t v [12];
      v[0]  = '{4'd0, 32'hFFFF_FFFF, 32'd1,          32'h0000_0000, 1};
      v[1]  = '{4'd1, 32'd5,         32'd7,          32'hFFFF_FFFE, 1};
      v[2]  = '{4'd8, 32'hFFFF_FFFF, 32'd1,          32'd1,         1};
      v[3]  = '{4'd9, 32'hFFFF_FFFF, 32'd1,          32'd0,         1};
      v[4]  = '{4'd5, 32'hA5A5_A5A5, 32'hFFFF_0000,  32'h5A5A_A5A5, 1};
      v[5]  = '{4'd4, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 32};
      v[6]  = '{4'd3, 32'h8000_0000, 32'd31,         32'h0000_0001, 32};
      v[7]  = '{4'd2, 32'd1,         32'd0,          32'd1,         1};
      v[8]  = '{4'd6, 32'h0F0F_0000, 32'h0000_F0F0,  32'h0F0F_F0F0, 1};
      v[9]  = '{4'd7, 32'hFF00_FF00, 32'h0FF0_0FF0,  32'h0F00_0F00, 1};
      v[10] = '{4'd15, 32'd1,        32'd1,          32'd0,         1};
      v[11] = '{4'd2, 32'd1,         32'd33,         32'd2,         2};
      for (int i = 0; i < 12; i++)
         do_op(v[i].o, v[i].x, v[i].y, v[i].res, v[i].lat, $sformatf("directed%0d", i));
   endtask

   task automatic test_random;
      logic [3:0]  o;
      logic [31:0] x, y;
      for (int i = 0; i < 60; i++) begin
         o = 4'($urandom_range(0, 15));
         x = $urandom;
         y = $urandom;
         do_op(o, x, y, ref_result(o, x, y), ref_latency(o, y), $sformatf("random%0d", i));
      end
   endtask

   task automatic test_backpressure;
      int  cycles;
      bit  hold_ok;
      op = OP_SLL; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      cycles = 1;
      while (out_valid !== 1'b1 && cycles < 100) begin
         step();
         cycles++;
      end
      n_tests++;
      if (cycles != 5) begin
         n_fail++;
         $display("FAIL bp_latency: got %0d want 5", cycles);
      end
      hold_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || result !== 32'h30 || in_ready !== 1'b0) hold_ok = 1'b0;
         step();
      end
      n_tests++;
      if (!hold_ok || out_valid !== 1'b1 || result !== 32'h30) begin
         n_fail++;
         $display("FAIL bp_hold: out_valid=%b result=%h want 1/00000030", out_valid, result);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_flush;
      bit never_valid;
      do_op(4'd0, 32'd7, 32'd8, 32'd15, 1, "pre_flush_add");
      op = OP_SLL; a = 32'd1; b = 32'd10; in_valid = 1'b1;
      step();                       // accepted; now in 1st shift cycle
      in_valid = 1'b0;
      step(); step();               // now in 3rd shift cycle
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_busy: in_ready=%b want 0", in_ready);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd15 || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_abort: in_ready=%b out_valid=%b result=%h zero=%b want 1/0/0000000f/0",
                  in_ready, out_valid, result, zero);
      end
      never_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (out_valid !== 1'b0) never_valid = 1'b0;
         step();
      end
      n_tests++;
      if (!never_valid) begin
         n_fail++;
         $display("FAIL flush_discard: out_valid rose after flush");
      end
      // flush and in_valid together in IDLE: no accept.
      op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd15) begin
         n_fail++;
         $display("FAIL flush_vs_valid: out_valid=%b in_ready=%b result=%h want 0/1/0000000f",
                  out_valid, in_ready, result);
      end
   endtask

   task automatic test_reset_in_done;
      op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || result !== 32'd2) begin
         n_fail++;
         $display("FAIL rst_setup: out_valid=%b result=%h want 1/00000002", out_valid, result);
      end
      rst = 1'b1; flush = 1'b1;     // reset wins over flush
      step();
      rst = 1'b0; flush = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_in_done: out_valid=%b result=%h zero=%b in_ready=%b want 0/0/1/1",
                  out_valid, result, zero, in_ready);
      end
      do_op(4'd0, 32'd2, 32'd3, 32'd5, 1, "post_rst_add");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_flush();
      test_reset_in_done();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
